// File: rtl/mem_access_pkg.sv
// Shared state, opcode and size encodings for the MEM-stage data-memory access controller.
package mem_access_pkg;

   localparam int TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic [1:0] MEMWR_NONE  = 2'b00;
   localparam logic [1:0] MEMWR_LOAD  = 2'b01;
   localparam logic [1:0] MEMWR_STORE = 2'b10;
   localparam logic [1:0] MEMWR_RSVD  = 2'b11;

   localparam logic [1:0] SIZE_BYTE     = 2'b00;
   localparam logic [1:0] SIZE_HALF     = 2'b01;
   localparam logic [1:0] SIZE_WORD     = 2'b10;
   localparam logic [1:0] SIZE_WORD_ALT = 2'b11;

   function automatic logic is_op_valid(input logic [1:0] memwr);
      return (memwr == MEMWR_LOAD) || (memwr == MEMWR_STORE);
   endfunction

   // Size code 11 behaves as a word, so anything not byte/half needs a word-aligned address.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = addr_lo[0];
         default:   mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and SRAM-side signals of the MEM-stage access controller.
// The controller uses the slave view; the surrounding pipeline/SRAM model uses the master view.
interface mem_access_ctrl_if;
   logic [1:0]  mem_MemWr;
   logic [31:0] mem_addr;
   logic [1:0]  mem_size;
   logic        mem_sign;
   logic [31:0] mem_wdata;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        stall;
   logic [31:0] rdata_out;
   logic        done;
   logic        exc_misalign;
   logic        exc_bus;

   modport slave (
      input  mem_MemWr, mem_addr, mem_size, mem_sign, mem_wdata, dm_rdata, dm_ack,
      output dm_req, dm_we, dm_addr, dm_be, dm_wdata, stall, rdata_out, done,
             exc_misalign, exc_bus
   );

   modport master (
      output mem_MemWr, mem_addr, mem_size, mem_sign, mem_wdata, dm_rdata, dm_ack,
      input  dm_req, dm_we, dm_addr, dm_be, dm_wdata, stall, rdata_out, done,
             exc_misalign, exc_bus
   );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables and data replication, load shift and sign/zero extension.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  st_size_i,
   input  logic [1:0]  st_addr_lo_i,
   input  logic [31:0] st_wdata_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_wdata_o,
   input  logic [1:0]  ld_size_i,
   input  logic [1:0]  ld_addr_lo_i,
   input  logic        ld_sign_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_rdata_o
);

   logic [31:0] shifted_s;

   // Store lanes: narrow data is copied into every lane so the SRAM just applies dm_be.
   always_comb begin
      st_be_o    = 4'b1111;
      st_wdata_o = st_wdata_i;
      case (st_size_i)
         SIZE_BYTE: begin
            st_be_o    = 4'b0001 << st_addr_lo_i;
            st_wdata_o = {4{st_wdata_i[7:0]}};
         end
         SIZE_HALF: begin
            st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
            st_wdata_o = {2{st_wdata_i[15:0]}};
         end
         default: begin
            st_be_o    = 4'b1111;
            st_wdata_o = st_wdata_i;
         end
      endcase
   end

   // Load path: bring the addressed lane down to bit 0, then extend to 32 bits.
   always_comb begin
      shifted_s  = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
      ld_rdata_o = shifted_s;
      case (ld_size_i)
         SIZE_BYTE: begin
            if (ld_sign_i) begin
               ld_rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end else begin
               ld_rdata_o = {24'h000000, shifted_s[7:0]};
            end
         end
         SIZE_HALF: begin
            if (ld_sign_i) begin
               ld_rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end else begin
               ld_rdata_o = {16'h0000, shifted_s[15:0]};
            end
         end
         default: ld_rdata_o = shifted_s;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: stalls the pipeline while one SRAM transfer
// runs, flags misaligned accesses and SRAM timeouts, and returns aligned load data.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   mem_access_ctrl_if.slave mem_if
);

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [29:0]        addr_q, addr_d;
   logic [1:0]         addr_lo_q, addr_lo_d;
   logic [1:0]         size_q, size_d;
   logic               sign_q, sign_d;
   logic [3:0]         be_q, be_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               exc_mis_q, exc_mis_d;
   logic               exc_bus_q, exc_bus_d;

   logic               op_valid_s;
   logic               misaligned_s;
   logic               stall_s;
   logic [3:0]         be_s;
   logic [31:0]        wdata_rep_s;
   logic [31:0]        ld_data_s;

   assign op_valid_s   = is_op_valid(mem_if.mem_MemWr);
   assign misaligned_s = is_misaligned(mem_if.mem_size, mem_if.mem_addr[1:0]);

   // Store steering uses the live request; load steering uses the attributes latched at issue.
   mem_lane_align u_lane_align (
      .st_size_i    (mem_if.mem_size),
      .st_addr_lo_i (mem_if.mem_addr[1:0]),
      .st_wdata_i   (mem_if.mem_wdata),
      .st_be_o      (be_s),
      .st_wdata_o   (wdata_rep_s),
      .ld_size_i    (size_q),
      .ld_addr_lo_i (addr_lo_q),
      .ld_sign_i    (sign_q),
      .ld_rdata_i   (mem_if.dm_rdata),
      .ld_rdata_o   (ld_data_s)
   );

   // Next-state and stall decode; exception flags live only for the single DONE cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      addr_lo_d = addr_lo_q;
      size_d    = size_q;
      sign_d    = sign_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      exc_mis_d = 1'b0;
      exc_bus_d = 1'b0;
      stall_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (op_valid_s) begin
               stall_s = 1'b1;
               if (misaligned_s) begin
                  state_d   = ST_DONE;
                  exc_mis_d = 1'b1;
               end else begin
                  state_d   = ST_REQ;
                  cnt_d     = {CNT_W{1'b0}};
                  we_d      = (mem_if.mem_MemWr == MEMWR_STORE);
                  addr_d    = mem_if.mem_addr[31:2];
                  addr_lo_d = mem_if.mem_addr[1:0];
                  size_d    = mem_if.mem_size;
                  sign_d    = mem_if.mem_sign;
                  be_d      = be_s;
                  wdata_d   = wdata_rep_s;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            stall_s = 1'b1;
            if (mem_if.dm_ack) begin
               state_d = ST_DONE;
               if (!we_q) begin
                  rdata_d = ld_data_s;
               end else begin
                  rdata_d = rdata_q;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_DONE;
               exc_bus_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset; reset also drops any pending dm_ack.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         we_q      <= 1'b0;
         addr_q    <= 30'd0;
         addr_lo_q <= 2'b00;
         size_q    <= 2'b00;
         sign_q    <= 1'b0;
         be_q      <= 4'b0000;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
         exc_mis_q <= 1'b0;
         exc_bus_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         addr_lo_q <= addr_lo_d;
         size_q    <= size_d;
         sign_q    <= sign_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         exc_mis_q <= exc_mis_d;
         exc_bus_q <= exc_bus_d;
      end
   end

   assign mem_if.dm_req       = (state_q == ST_REQ);
   assign mem_if.dm_we        = we_q;
   assign mem_if.dm_addr      = {addr_q, 2'b00};
   assign mem_if.dm_be        = be_q;
   assign mem_if.dm_wdata     = wdata_q;
   assign mem_if.stall        = stall_s;
   assign mem_if.rdata_out    = rdata_q;
   assign mem_if.done         = (state_q == ST_DONE);
   assign mem_if.exc_misalign = exc_mis_q;
   assign mem_if.exc_bus      = exc_bus_q;

endmodule
